// File: rtl/axil_pkg.sv
// Shared types and constants for the AXI4-Lite request arbiter.
// Holds the sequencer state encoding and the op-code values.
package axil_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int ADDR_WIDTH_DEF = 2;
    localparam int DATA_WIDTH_DEF = 8;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/axil_req_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit at or
// above the pointer, wrapping around the requester count.
module rr_pick #(
    parameter int N_REQ = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] rr_ptr_i,
    output logic [IDX_W-1:0] grant_o,
    output logic             any_req_o
);

    int idx;

    // Walk offsets from the far end so the nearest offset wins last.
    always_comb begin
        grant_o   = '0;
        any_req_o = 1'b0;
        idx       = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_i) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (req_i[idx]) begin
                grant_o   = IDX_W'(idx);
                any_req_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axil_req_arbiter.sv
// Shares one AXI4-Lite master command port between N_REQ requesters:
// round-robin grant, one start pulse, wait for done or timeout, respond.
module axil_req_arbiter
    import axil_pkg::*;
#(
    parameter int N_REQ      = 2,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int TIMEOUT    = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ-1:0]            req_write,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [N_REQ-1:0]            rsp_valid,
    output logic                        rsp_err,
    output logic [DATA_WIDTH-1:0]       rsp_rdata,
    output logic                        busy,
    output logic                        mst_start_write,
    output logic                        mst_start_read,
    output logic [ADDR_WIDTH-1:0]       mst_waddr,
    output logic [ADDR_WIDTH-1:0]       mst_raddr,
    output logic [DATA_WIDTH-1:0]       mst_wdata,
    input  logic                        mst_done,
    input  logic [DATA_WIDTH-1:0]       mst_rdata
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT);

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      gnt_q, gnt_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic                  op_q, op_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic [IDX_W-1:0]      pick;
    logic                  any_req;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i     (req_valid),
        .rr_ptr_i  (ptr_q),
        .grant_o   (pick),
        .any_req_o (any_req)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
            op_q    <= OP_READ;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    gnt_d   = pick;
                    op_d    = req_write[pick];
                    addr_d  = req_addr[pick*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d = req_wdata[pick*DATA_WIDTH +: DATA_WIDTH];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (mst_done) begin
                    rdata_d = (op_q == OP_WRITE) ? '0 : mst_rdata;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                ptr_d   = (gnt_q == IDX_W'(N_REQ - 1)) ? '0 : gnt_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rsp_valid       = '0;
        rsp_err         = 1'b0;
        rsp_rdata       = '0;
        busy            = (state_q != IDLE);
        mst_start_write = (state_q == ISSUE) && (op_q == OP_WRITE);
        mst_start_read  = (state_q == ISSUE) && (op_q == OP_READ);
        mst_waddr       = '0;
        mst_raddr       = '0;
        mst_wdata       = '0;
        // The unused address channel stays at zero for the whole transaction.
        if (state_q != IDLE) begin
            mst_waddr = (op_q == OP_WRITE) ? addr_q : '0;
            mst_raddr = (op_q == OP_READ) ? addr_q : '0;
            mst_wdata = wdata_q;
        end
        if (state_q == RESP) begin
            rsp_valid[gnt_q] = 1'b1;
            rsp_err          = err_q;
            rsp_rdata        = rdata_q;
        end
    end

endmodule

// File: tb/tb_axil_req_arbiter.sv
// Self-checking bench for axil_req_arbiter: directed test-plan steps
// followed by randomized traffic against a round-robin reference model.
module tb_axil_req_arbiter;

    localparam int N  = 2;
    localparam int AW = 2;
    localparam int DW = 8;
    localparam int TO = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_write;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    rsp_valid;
    logic            rsp_err;
    logic [DW-1:0]   rsp_rdata;
    logic            busy;
    logic            mst_start_write;
    logic            mst_start_read;
    logic [AW-1:0]   mst_waddr;
    logic [AW-1:0]   mst_raddr;
    logic [DW-1:0]   mst_wdata;
    logic            mst_done;
    logic [DW-1:0]   mst_rdata;

    int checks = 0;
    int fails  = 0;
    int ptr    = 0;

    logic          m_w  [N];
    logic [AW-1:0] m_a  [N];
    logic [DW-1:0] m_wd [N];

    always #5 clk = ~clk;

    axil_req_arbiter #(
        .N_REQ      (N),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TO)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_write       (req_write),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .rsp_valid       (rsp_valid),
        .rsp_err         (rsp_err),
        .rsp_rdata       (rsp_rdata),
        .busy            (busy),
        .mst_start_write (mst_start_write),
        .mst_start_read  (mst_start_read),
        .mst_waddr       (mst_waddr),
        .mst_raddr       (mst_raddr),
        .mst_wdata       (mst_wdata),
        .mst_done        (mst_done),
        .mst_rdata       (mst_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd);
        m_w[i]  = w;
        m_a[i]  = a;
        m_wd[i] = wd;
        req_valid[i]          = 1'b1;
        req_write[i]          = w;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = wd;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_err"}, rsp_err, 0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_start"}, {mst_start_write, mst_start_read}, 0);
        chk({tag, "_addr"}, {mst_waddr, mst_raddr, mst_wdata}, 0);
    endtask

    // Plays the master for granted requester g; done is raised d cycles
    // after the start pulse (d > TO means the master never answers).
    task automatic serve(input int g, input int d, input logic [DW-1:0] rd,
                         input bit mutate);
        int n;
        int t;
        int exp_t;
        bit seen;
        logic [DW-1:0] exp_rd;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 8) begin
            tick();
            n++;
            seen = mst_start_write | mst_start_read;
        end
        chk("start_seen", seen, 1);
        if (!seen) return;
        chk("start_wr", mst_start_write, m_w[g]);
        chk("start_rd", mst_start_read, !m_w[g]);
        chk("waddr", mst_waddr, m_w[g] ? m_a[g] : 0);
        chk("raddr", mst_raddr, m_w[g] ? 0 : m_a[g]);
        if (m_w[g]) chk("wdata", mst_wdata, m_wd[g]);
        chk("busy_issue", busy, 1);
        exp_t  = (d > TO) ? TO + 1 : d + 1;
        exp_rd = (d > TO || m_w[g]) ? '0 : rd;
        seen   = 1'b0;
        t      = 0;
        while (!seen && t < TO + 4) begin
            tick();
            t++;
            if (mst_done) begin
                mst_done  = 1'b0;
                mst_rdata = '0;
            end
            seen = |rsp_valid;
            if (!seen && t == d) begin
                mst_done  = 1'b1;
                mst_rdata = rd;
            end
            if (mutate && t == 1) begin
                req_addr[g*AW +: AW] = m_a[g] ^ 2'b11;
                req_valid[g]         = 1'b0;
            end
        end
        chk("rsp_seen", seen, 1);
        if (seen) begin
            chk("rsp_time", t, exp_t);
            chk("rsp_valid", rsp_valid, 1 << g);
            chk("rsp_err", rsp_err, d > TO);
            chk("rsp_rdata", rsp_rdata, exp_rd);
            chk("addr_held", m_w[g] ? mst_waddr : mst_raddr, m_a[g]);
        end
        req_valid[g] = 1'b0;
        mst_done     = 1'b0;
        ptr          = (g + 1) % N;
    endtask

    initial begin
        int g;
        int d;
        int n;
        rst_n     = 1'b0;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        mst_done  = 1'b0;
        mst_rdata = '0;
        tick();
        tick();
        chk_idle_outputs("reset");
        rst_n = 1'b1;
        tick();

        set_req(0, 1'b1, 2'd2, 8'h04);
        serve(pick(req_valid, ptr), 3, 8'h00, 1'b0);

        set_req(1, 1'b0, 2'd2, 8'h00);
        serve(pick(req_valid, ptr), 2, 8'h04, 1'b0);

        set_req(0, 1'b1, 2'd1, 8'h11);
        set_req(1, 1'b0, 2'd3, 8'h00);
        for (int k = 0; k < 3; k++) begin
            g = pick(req_valid, ptr);
            chk("contention_grant", g, k % 2);
            serve(g, 2, 8'hA0 + 8'(k), 1'b0);
            set_req(g, m_w[g], m_a[g], m_wd[g]);
        end
        req_valid = '0;

        set_req(0, 1'b0, 2'd1, 8'h00);
        serve(pick(req_valid, ptr), TO + 10, 8'h77, 1'b0);
        set_req(1, 1'b0, 2'd2, 8'h00);
        serve(pick(req_valid, ptr), TO, 8'h5A, 1'b0);
        set_req(0, 1'b0, 2'd3, 8'h00);
        serve(pick(req_valid, ptr), TO + 1, 8'h66, 1'b0);

        tick();
        mst_done  = 1'b1;
        mst_rdata = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("idle_done_busy", busy, 0);
            chk("idle_done_rsp", rsp_valid, 0);
        end
        mst_done  = 1'b0;
        mst_rdata = '0;

        set_req(0, 1'b1, 2'd2, 8'h3C);
        serve(pick(req_valid, ptr), 4, 8'h00, 1'b1);

        set_req(0, 1'b0, 2'd3, 8'h00);
        n = 0;
        while (!(mst_start_read | mst_start_write) && n < 8) begin
            tick();
            n++;
        end
        chk("rst_txn_start", mst_start_read, 1);
        tick();
        rst_n = 1'b0;
        tick();
        chk_idle_outputs("midreset");
        req_valid = '0;
        rst_n     = 1'b1;
        ptr       = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post_reset_rsp", rsp_valid, 0);
            chk("post_reset_busy", busy, 0);
        end
        set_req(0, 1'b1, 2'd1, 8'h81);
        set_req(1, 1'b1, 2'd2, 8'h82);
        g = pick(req_valid, ptr);
        chk("post_reset_grant", g, 0);
        serve(g, 1, 8'h00, 1'b0);
        req_valid = '0;

        for (int it = 0; it < 24; it++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
                    set_req(i, 1'($urandom), AW'($urandom), DW'($urandom));
                end
            end
            if (req_valid == '0) begin
                set_req(it % N, 1'($urandom), AW'($urandom), DW'($urandom));
            end
            g = pick(req_valid, ptr);
            d = ($urandom_range(0, 7) == 0) ? TO + 3 : $urandom_range(1, 5);
            serve(g, d, DW'($urandom), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule

// File: doc/axil_req_arbiter.md
Name: axil_req_arbiter

Overview:
Round-robin arbiter and sequencer that shares the single AXI4-Lite master command port of the top-level AXI4-Lite block between N_REQ requesters.
- Accepts one read or write request per requester.
- Issues it as a one-cycle start pulse with address and data.
- Waits for the master's done, then returns read data or an error to the granted requester.
- Sits between on-chip requesters (test sequencers, config loaders) and the master's start_write/start_read/done interface.

Parameters:
N_REQ, 2, number of requesters (2..8)
ADDR_WIDTH, 2, AXI4-Lite address width
DATA_WIDTH, 8, AXI4-Lite data width
TIMEOUT, 32, max WAIT cycles before an error response (>=2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
req_valid  input  N_REQ  per-requester request, held high until that requester's rsp_valid
req_write  input  N_REQ  per-requester op: 1 = write, 0 = read
req_addr  input  N_REQ*ADDR_WIDTH  per-requester address, requester i at slice [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  input  N_REQ*DATA_WIDTH  per-requester write data, same slicing
rsp_valid  output  N_REQ  one-cycle completion pulse to the granted requester
rsp_err  output  1  qualifies rsp_valid: 1 = timeout
rsp_rdata  output  DATA_WIDTH  read data, valid with rsp_valid
busy  output  1  high whenever state != IDLE
mst_start_write  output  1  one-cycle write start to master
mst_start_read  output  1  one-cycle read start to master
mst_waddr  output  ADDR_WIDTH  write address, held from ISSUE through RESP
mst_raddr  output  ADDR_WIDTH  read address, held from ISSUE through RESP
mst_wdata  output  DATA_WIDTH  write data, held from ISSUE through RESP
mst_done  input  1  master transaction complete (level or pulse)
mst_rdata  input  DATA_WIDTH  master read data, valid when mst_done=1

Behaviour:
- Reset (rst_n=0 at a clk edge), regardless of state:
  - state=IDLE; rr_ptr=0.
  - All outputs 0: rsp_valid, rsp_err, rsp_rdata, busy, mst_start_*, mst_waddr, mst_raddr, mst_wdata.
  - Timeout counter 0.
  - Reset mid-transaction abandons it; no response is issued.
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any req_valid is high, select the first set bit searching from rr_ptr upward, wrapping modulo N_REQ.
  - Latch grant index, op, addr and wdata into registers; go to ISSUE.
  - If no request, stay in IDLE.
- ISSUE (1 cycle):
  - Pulse mst_start_write or mst_start_read per the latched op.
  - Drive mst_waddr/mst_raddr/mst_wdata from the latched values; the unused address output is held 0.
  - Clear the counter; go to WAIT.
- WAIT:
  - mst_done is ignored during ISSUE and sampled only in WAIT.
  - If mst_done=1: capture mst_rdata (reads only; writes capture 0); go to RESP with err=0.
  - Else, if counter == TIMEOUT-1: go to RESP with err=1, rdata=0.
  - Else increment the counter.
- RESP (1 cycle):
  - rsp_valid[grant]=1; rsp_err and rsp_rdata driven.
  - rr_ptr <= (grant+1) mod N_REQ; go to IDLE.
- Latency: request seen in IDLE at edge k -> start pulse in cycle k+1 -> response 1 cycle after done is sampled. Minimum 4 cycles from request to rsp_valid.
- Request changes while granted:
  - Deasserting req_valid or changing addr/wdata after the grant has no effect; the transaction completes and responds on the latched values.
  - A requester that keeps req_valid high after its rsp_valid is a new request.
- Arbitration fairness: simultaneous requests are served round-robin; no requester waits more than N_REQ-1 other transactions.
- No back-to-back overlap: only one outstanding transaction. mst_done arriving in IDLE, ISSUE or RESP is ignored.
- busy=1 in ISSUE, WAIT and RESP.
- Timeout is reached after exactly TIMEOUT WAIT cycles; a done arriving after a timeout is ignored.

Decomposition:
- Shared package axil_pkg holds:
  - state enum (IDLE, ISSUE, WAIT, RESP);
  - default ADDR_WIDTH/DATA_WIDTH;
  - OP_READ/OP_WRITE constants.
- One sub-module, rr_pick: combinational round-robin priority picker.
  - Inputs: req vector, rr_ptr.
  - Outputs: grant index, any_req.
- FSM, latches and counter live in axil_req_arbiter.

Test Plan:
- Single write: req 0 writes addr=2 data=0x04; done returned 3 cycles after start -> one mst_start_write pulse, mst_waddr=2, mst_wdata=0x04, rsp_valid[0] pulse with err=0.
- Single read: req 1 reads addr=2; master returns 0x04 with done -> mst_start_read pulse, mst_raddr=2, rsp_valid[1] with rsp_rdata=0x04.
- Contention: both requesters assert in the same cycle from reset (rr_ptr=0) -> req 0 served first, then req 1, then (both re-asserted) req 0 again; strict alternation.
- Timeout: TIMEOUT=32, mst_done never asserted -> rsp_valid with rsp_err=1, rsp_rdata=0 exactly 32 cycles after entering WAIT; FSM returns to IDLE.
- Mid-op reset: rst_n low for 1 cycle during WAIT -> all outputs 0 next cycle, no rsp_valid, next request arbitrated from rr_ptr=0.
- Request change after grant: req 0 changes addr 2->1 and drops req_valid during WAIT -> master still sees addr 2; rsp_valid[0] still pulses.
